// File: rtl/alu_wb_buffer.sv
// Write-back buffer between the vector lane ALU and the VRF write port.
// Captures parallel ALU result beats in a small circular FIFO, packs
// per-element compare mask bits into full OP_WIDTH words, and raises an
// ALU stall early enough that beats already in flight still fit.
//
// Handshake: an entry leaves the FIFO on a cycle where wb_vld_o and wb_rdy_i
// are both high; wb_* stay stable while wb_vld_o=1 and wb_rdy_i=0. The input
// side has no ready; the producer must honour alu_stall_o.
module alu_wb_buffer #(
  parameter int OP_WIDTH        = 32,
  parameter int PARALLEL_IF_NUM = 4,
  parameter int DEPTH           = 8,
  parameter int ALU_LATENCY     = 3,
  parameter int ADDR_W          = 5
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush_i,
  input  logic [PARALLEL_IF_NUM-1:0]          in_vld_i,
  input  logic [PARALLEL_IF_NUM*OP_WIDTH-1:0] in_data_i,
  input  logic [PARALLEL_IF_NUM-1:0]          in_mask_i,
  input  logic                                mask_op_i,
  input  logic                                mask_last_i,
  input  logic [ADDR_W-1:0]                   waddr_i,
  output logic                                alu_stall_o,
  output logic                                wb_vld_o,
  input  logic                                wb_rdy_i,
  output logic [PARALLEL_IF_NUM*OP_WIDTH-1:0] wb_data_o,
  output logic [PARALLEL_IF_NUM-1:0]          wb_we_o,
  output logic [ADDR_W-1:0]                   wb_addr_o,
  output logic                                ovf_err_o,
  output logic                                seq_err_o
);

  localparam int P     = PARALLEL_IF_NUM;
  localparam int DW    = P * OP_WIDTH;
  localparam int NPOS  = OP_WIDTH / P;
  localparam int POS_W = (NPOS > 1) ? $clog2(NPOS) : 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [POS_W-1:0] LAST_POS = POS_W'(NPOS - 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] STALL_C  = CNT_W'(DEPTH - ALU_LATENCY);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PACK = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic [OP_WIDTH-1:0] pack_q, pack_d;
  logic [ADDR_W-1:0]   word_addr_q, word_addr_d;

  logic [CNT_W-1:0]    count_q, count_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic                ovf_q, ovf_d;
  logic                seq_q, seq_d;

  logic [DW-1:0]       mem_data_q [DEPTH];
  logic [P-1:0]        mem_we_q   [DEPTH];
  logic [ADDR_W-1:0]   mem_addr_q [DEPTH];

  logic                beat;
  logic                push_req;
  logic                push_acc;
  logic                pop;
  logic                seq_set;
  logic [DW-1:0]       push_data;
  logic [P-1:0]        push_we;
  logic [ADDR_W-1:0]   push_addr;
  logic [OP_WIDTH-1:0] beat_bits;
  logic [OP_WIDTH-1:0] packed_word;
  logic [ADDR_W-1:0]   cur_word_addr;

  assign beat = |in_vld_i;

  // Packer FSM next state and selection of the entry to push this cycle.
  always_comb begin
    state_d       = state_q;
    pos_d         = pos_q;
    pack_d        = pack_q;
    word_addr_d   = word_addr_q;
    push_req      = 1'b0;
    push_data     = '0;
    push_we       = '0;
    push_addr     = '0;
    seq_set       = 1'b0;
    // Invalid lanes contribute a zero mask bit; the slot is always zero
    // beforehand because pack_q is cleared whenever a word completes.
    beat_bits     = OP_WIDTH'(in_vld_i & in_mask_i) << (pos_q * P);
    packed_word   = pack_q | beat_bits;
    cur_word_addr = (state_q == S_IDLE) ? waddr_i : word_addr_q;
    if (beat) begin
      if (mask_op_i) begin
        if ((pos_q == LAST_POS) || mask_last_i) begin
          push_req               = 1'b1;
          push_data[OP_WIDTH-1:0] = packed_word;
          push_we[0]             = 1'b1;
          push_addr              = cur_word_addr;
          pack_d                 = '0;
          pos_d                  = '0;
          state_d                = S_IDLE;
        end else begin
          pack_d      = packed_word;
          pos_d       = pos_q + 1'b1;
          word_addr_d = cur_word_addr;
          state_d     = S_PACK;
        end
      end else begin
        if (state_q == S_PACK) begin
          seq_set = 1'b1;
          pack_d  = '0;
          pos_d   = '0;
          state_d = S_IDLE;
        end
        push_req  = 1'b1;
        push_data = in_data_i;
        push_we   = in_vld_i;
        push_addr = waddr_i;
      end
    end
  end

  // FIFO occupancy, pointer advance and sticky error flags.
  always_comb begin
    pop      = (count_q != '0) && wb_rdy_i;
    push_acc = push_req && ((count_q != DEPTH_C) || pop);
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_acc && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push_acc && pop) begin
      count_d = count_q - 1'b1;
    end
    if (push_acc) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    end
    ovf_d = ovf_q | (push_req & ~push_acc);
    seq_d = seq_q | seq_set;
  end

  // Control state registers; rst and flush both clear everything.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      state_q     <= S_IDLE;
      pos_q       <= '0;
      pack_q      <= '0;
      word_addr_q <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ovf_q       <= 1'b0;
      seq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      pack_q      <= pack_d;
      word_addr_q <= word_addr_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ovf_q       <= ovf_d;
      seq_q       <= seq_d;
    end
  end

  // Entry storage; contents need no reset because outputs are gated by valid.
  always_ff @(posedge clk) begin
    if (!rst && !flush_i && push_acc) begin
      mem_data_q[wr_ptr_q] <= push_data;
      mem_we_q[wr_ptr_q]   <= push_we;
      mem_addr_q[wr_ptr_q] <= push_addr;
    end
  end

  assign wb_vld_o    = (count_q != '0);
  assign wb_data_o   = wb_vld_o ? mem_data_q[rd_ptr_q] : '0;
  assign wb_we_o     = wb_vld_o ? mem_we_q[rd_ptr_q]   : '0;
  assign wb_addr_o   = wb_vld_o ? mem_addr_q[rd_ptr_q] : '0;
  assign alu_stall_o = (count_q >= STALL_C);
  assign ovf_err_o   = ovf_q;
  assign seq_err_o   = seq_q;

endmodule

// File: tb/tb_alu_wb_buffer.sv
// Bench for alu_wb_buffer: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a queue model.
module tb_alu_wb_buffer;

  localparam int EW = 128 + 4 + 5;

  logic         clk;
  logic         rst;
  logic         flush_i;
  logic [3:0]   in_vld_i;
  logic [127:0] in_data_i;
  logic [3:0]   in_mask_i;
  logic         mask_op_i;
  logic         mask_last_i;
  logic [4:0]   waddr_i;
  logic         alu_stall_o;
  logic         wb_vld_o;
  logic         wb_rdy_i;
  logic [127:0] wb_data_o;
  logic [3:0]   wb_we_o;
  logic [4:0]   wb_addr_o;
  logic         ovf_err_o;
  logic         seq_err_o;

  int checks;
  int errors;
  bit cmp_en;

  alu_wb_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .in_vld_i    (in_vld_i),
    .in_data_i   (in_data_i),
    .in_mask_i   (in_mask_i),
    .mask_op_i   (mask_op_i),
    .mask_last_i (mask_last_i),
    .waddr_i     (waddr_i),
    .alu_stall_o (alu_stall_o),
    .wb_vld_o    (wb_vld_o),
    .wb_rdy_i    (wb_rdy_i),
    .wb_data_o   (wb_data_o),
    .wb_we_o     (wb_we_o),
    .wb_addr_o   (wb_addr_o),
    .ovf_err_o   (ovf_err_o),
    .seq_err_o   (seq_err_o)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: FIFO contents as a queue of {data, we, addr}
  logic [EW-1:0] exp_q[$];
  bit            m_ovf;
  bit            m_seq;
  bit            m_active;
  int            m_pos;
  logic [31:0]   m_word;
  logic [4:0]    m_addr;

  always @(posedge clk) begin
    logic [EW-1:0] pe;
    bit            has_push;
    bit            do_pop;
    int            sz;
    pe = '0;
    if (rst || flush_i) begin
      exp_q.delete();
      m_ovf = 0; m_seq = 0; m_active = 0; m_pos = 0; m_word = '0;
    end else begin
      sz       = exp_q.size();
      do_pop   = (sz != 0) && wb_rdy_i;
      has_push = 0;
      if (in_vld_i != 4'b0) begin
        if (mask_op_i) begin
          if (!m_active) begin
            m_active = 1; m_addr = waddr_i; m_pos = 0; m_word = '0;
          end
          for (int i = 0; i < 4; i++)
            if (in_vld_i[i] && in_mask_i[i]) m_word = m_word + (32'd1 << (m_pos * 4 + i));
          if (m_pos == 7 || mask_last_i) begin
            pe = {96'b0, m_word, 4'b0001, m_addr};
            has_push = 1;
            m_active = 0; m_pos = 0; m_word = '0;
          end else begin
            m_pos = m_pos + 1;
          end
        end else begin
          if (m_active) begin
            m_seq = 1; m_active = 0; m_pos = 0; m_word = '0;
          end
          pe = {in_data_i, in_vld_i, waddr_i};
          has_push = 1;
        end
      end
      if (do_pop) void'(exp_q.pop_front());
      if (has_push) begin
        if (sz < 8 || do_pop) exp_q.push_back(pe);
        else m_ovf = 1;
      end
    end
  end

  // Scoreboard comparison helper
  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Per-cycle compare of DUT outputs against the model
  always @(negedge clk) begin
    logic [EW-1:0] head;
    if (cmp_en) begin
      head = (exp_q.size() != 0) ? exp_q[0] : '0;
      chk("m_vld",   EW'(wb_vld_o),    EW'(exp_q.size() != 0));
      chk("m_stall", EW'(alu_stall_o), EW'(exp_q.size() >= 5));
      chk("m_ovf",   EW'(ovf_err_o),   EW'(m_ovf));
      chk("m_seq",   EW'(seq_err_o),   EW'(m_seq));
      chk("m_entry", {wb_data_o, wb_we_o, wb_addr_o}, head);
    end
  end

  // Driver tasks
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    in_vld_i = '0; mask_op_i = 0; mask_last_i = 0; flush_i = 0;
  endtask

  task automatic beat(input logic [3:0] v, input logic [127:0] d, input logic [3:0] m,
                      input logic mop, input logic mlast, input logic [4:0] a);
    in_vld_i = v; in_data_i = d; in_mask_i = m;
    mask_op_i = mop; mask_last_i = mlast; waddr_i = a;
    cyc();
    idle();
  endtask

  task automatic do_flush();
    flush_i = 1;
    cyc();
    flush_i = 0;
  endtask

  task automatic drain();
    wb_rdy_i = 1;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) cyc();
    chk("drain_empty", EW'(wb_vld_o), EW'(0));
    wb_rdy_i = 0;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    checks = 0; errors = 0; cmp_en = 0;
    rst = 1; wb_rdy_i = 0; in_data_i = '0; in_mask_i = '0; waddr_i = '0;
    idle();
    @(posedge clk);
    cmp_en = 1;
    @(negedge clk);
    cyc();
    rst = 0;
    // Reset state
    chk("rst_vld",   EW'(wb_vld_o),    EW'(0));
    chk("rst_stall", EW'(alu_stall_o), EW'(0));
    chk("rst_ovf",   EW'(ovf_err_o),   EW'(0));
    chk("rst_data",  EW'(wb_data_o),   EW'(0));

    // 1: single beat then pop
    beat(4'hF, 128'h44444444_33333333_22222222_11111111, 4'h0, 0, 0, 5'd5);
    chk("t1_vld",  EW'(wb_vld_o),  EW'(1));
    chk("t1_we",   EW'(wb_we_o),   EW'(4'hF));
    chk("t1_addr", EW'(wb_addr_o), EW'(5));
    chk("t1_data", EW'(wb_data_o), EW'(128'h44444444_33333333_22222222_11111111));
    wb_rdy_i = 1;
    cyc();
    chk("t1_popped", EW'(wb_vld_o), EW'(0));
    wb_rdy_i = 0;

    // 2: fill, stall threshold, overflow, flush
    for (int k = 1; k <= 8; k++) begin
      beat(4'hF, rnd128(), 4'h0, 0, 0, 5'(k));
      chk("t2_stall", EW'(alu_stall_o), EW'(k >= 5));
    end
    chk("t2_ovf_pre", EW'(ovf_err_o), EW'(0));
    beat(4'hF, rnd128(), 4'h0, 0, 0, 5'd9);
    chk("t2_ovf", EW'(ovf_err_o), EW'(1));
    chk("t2_head_addr", EW'(wb_addr_o), EW'(1));
    do_flush();
    chk("t2_fl_ovf", EW'(ovf_err_o), EW'(0));
    chk("t2_fl_vld", EW'(wb_vld_o),  EW'(0));

    // 3: full 8-beat mask word
    for (int k = 0; k < 8; k++) begin
      chk("t3_none_yet", EW'(wb_vld_o), EW'(0));
      beat(4'hF, rnd128(), 4'b1010, 1, 0, (k == 0) ? 5'd3 : 5'($urandom_range(0, 31)));
    end
    chk("t3_lane0", EW'(wb_data_o[31:0]), EW'(32'hAAAAAAAA));
    chk("t3_upper", EW'(wb_data_o[127:32]), EW'(0));
    chk("t3_we",    EW'(wb_we_o),   EW'(4'b0001));
    chk("t3_addr",  EW'(wb_addr_o), EW'(3));
    drain();

    // 4: mask word ended early by mask_last_i
    for (int k = 0; k < 3; k++) beat(4'hF, rnd128(), 4'hF, 1, k == 2, 5'd12);
    chk("t4_lane0", EW'(wb_data_o[31:0]), EW'(32'h00000FFF));
    chk("t4_addr",  EW'(wb_addr_o), EW'(12));
    drain();

    // 5: partial mask word abandoned by a normal beat
    beat(4'hF, rnd128(), 4'hF, 1, 0, 5'd1);
    beat(4'hF, rnd128(), 4'hF, 1, 0, 5'd1);
    beat(4'hF, 128'hDEAD, 4'h0, 0, 0, 5'd7);
    chk("t5_seq",  EW'(seq_err_o), EW'(1));
    chk("t5_addr", EW'(wb_addr_o), EW'(7));
    chk("t5_we",   EW'(wb_we_o),   EW'(4'hF));
    chk("t5_data", EW'(wb_data_o), EW'(128'hDEAD));
    drain();
    do_flush();

    // 6: full FIFO with simultaneous push and pop across pointer wrap
    for (int k = 0; k < 8; k++) beat(4'hF, rnd128(), 4'h0, 0, 0, 5'(k));
    wb_rdy_i = 1;
    for (int k = 0; k < 20; k++) beat(4'($urandom_range(1, 15)), rnd128(), 4'h0, 0, 0, 5'($urandom_range(0, 31)));
    chk("t6_ovf",   EW'(ovf_err_o),   EW'(0));
    chk("t6_stall", EW'(alu_stall_o), EW'(1));
    drain();

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      rst         = ($urandom_range(0, 299) == 0);
      flush_i     = ($urandom_range(0, 149) == 0);
      wb_rdy_i    = ($urandom_range(0, 2) != 0);
      in_vld_i    = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      if (alu_stall_o && $urandom_range(0, 3) != 0) in_vld_i = 4'h0;
      in_data_i   = rnd128();
      in_mask_i   = 4'($urandom_range(0, 15));
      mask_op_i   = ($urandom_range(0, 2) == 0);
      mask_last_i = ($urandom_range(0, 4) == 0);
      waddr_i     = 5'($urandom_range(0, 31));
      cyc();
    end
    rst = 0;
    idle();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_wb_buffer.md
Name: alu_wb_buffer

Overview:
- Write-back buffer directly downstream of the vector lane ALU.
- Captures the ALU's parallel result beats (PARALLEL_IF_NUM interfaces per beat) in a small FIFO and presents them to the VRF write port under a valid/ready handshake.
- Packs per-element compare mask bits into full OP_WIDTH mask words.
- Generates the ALU stall so that results already in the ALU pipeline never overflow the FIFO.

Parameters:
OP_WIDTH, 32, data width per interface; must be a multiple of PARALLEL_IF_NUM
PARALLEL_IF_NUM, 4, ALU interfaces per beat
DEPTH, 8, FIFO entries; must be > ALU_LATENCY
ALU_LATENCY, 3, maximum ALU beats still in flight after stall asserts
ADDR_W, 5, VRF write address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush_i  in  1  synchronous clear of FIFO, packer and error flags
in_vld_i  in  PARALLEL_IF_NUM  per-interface ALU result valid
in_data_i  in  PARALLEL_IF_NUM*OP_WIDTH  ALU results, interface i at [i*OP_WIDTH +: OP_WIDTH]
in_mask_i  in  PARALLEL_IF_NUM  per-interface mask bit (ALU result bit 0)
mask_op_i  in  1  beat belongs to a mask-producing instruction
mask_last_i  in  1  final beat of the mask instruction
waddr_i  in  ADDR_W  VRF destination address of the beat
alu_stall_o  out  1  stall request to the ALU
wb_vld_o  out  1  head entry valid
wb_rdy_i  in  1  VRF port accepts head entry
wb_data_o  out  PARALLEL_IF_NUM*OP_WIDTH  head data
wb_we_o  out  PARALLEL_IF_NUM  head per-interface write enables
wb_addr_o  out  ADDR_W  head address
ovf_err_o  out  1  sticky: beat dropped because FIFO was full
seq_err_o  out  1  sticky: partial mask word abandoned

Behaviour:
- A beat is present when in_vld_i != 0. There is no input ready; the producer obeys alu_stall_o.
- pop = wb_vld_o & wb_rdy_i. A push is accepted when count < DEPTH or pop is true in the same cycle.
- Normal beat (mask_op_i=0): push {in_data_i, we=in_vld_i, addr=waddr_i}.
- Mask packing state machine, states IDLE and PACK. pos counts 0..OP_WIDTH/PARALLEL_IF_NUM-1; pack_reg is OP_WIDTH bits.
  - Mask beat: for each i, pack_reg[pos*P+i] = in_vld_i[i] ? in_mask_i[i] : 0.
  - On the first mask beat of a word (IDLE), latch waddr_i as word address and go to PACK.
  - If pos == OP_WIDTH/P-1 or mask_last_i: push {packed word in interface 0 lanes, zeros elsewhere, we=0...01, latched addr}, clear pack_reg and pos, go to IDLE.
  - Otherwise pos++.
  - A normal beat arriving in PACK: discard the partial word, set seq_err_o, go to IDLE, and push the normal beat.
- Storage is a circular buffer with wrapping read/write pointers and count 0..DEPTH.
  - Push and pop in the same cycle leave count unchanged.
  - A pop on an empty FIFO is impossible because wb_vld_o=0.
- Latency: an entry pushed in cycle N appears on wb_vld_o/wb_* in cycle N+1 at the earliest. wb_* hold stable while wb_vld_o=1 and wb_rdy_i=0.
- wb_vld_o = (count != 0). wb_data_o, wb_we_o and wb_addr_o come from the entry at the read pointer.
- alu_stall_o = (count >= DEPTH-ALU_LATENCY), decoded from the registered count only; no dependency on in_vld_i or wb_rdy_i.
- Overflow: a push that is not accepted drops the beat (a mask beat still updates the packer) and sets ovf_err_o. Sticky until rst or flush_i.
- Reset/flush: count, pointers, pos, pack_reg and the state are cleared and the state goes to IDLE. Outputs: wb_vld_o=0, alu_stall_o=0, ovf_err_o=0, seq_err_o=0. wb_data_o, wb_we_o and wb_addr_o read as 0.
- rst and flush_i have priority over simultaneous push/pop; the input beat in that cycle is dropped without flagging.

Test Plan:
1. Reset, then one beat: in_vld_i=4'b1111, data lanes 0x11111111..0x44444444, waddr_i=5. Next cycle wb_vld_o=1, wb_we_o=4'hF, wb_addr_o=5 and the same data. With wb_rdy_i=1 the entry pops; the following cycle wb_vld_o=0.
2. wb_rdy_i=0, 8 back-to-back beats. alu_stall_o rises when count reaches 5. A 9th beat sets ovf_err_o=1 and count stays 8. flush_i then gives count=0 and ovf_err_o=0.
3. Mask op, 8 beats: in_mask_i=4'b1010, all lanes valid, waddr_i=3 on the first beat. Exactly one entry results: data lane0=0xAAAAAAAA, we=4'b0001, addr=3.
4. Mask op with mask_last_i on the 3rd beat, in_mask_i=4'b1111 each beat. One entry with lane0=0x00000FFF.
5. Two mask beats, then a normal beat with waddr_i=7. seq_err_o=1 and one FIFO entry holds the normal beat with addr=7.
6. FIFO full with wb_rdy_i=1 and a simultaneous push: no overflow, count stays 8, and ordering is preserved across pointer wrap over 20 beats.
